// File: rtl/mips_cpu_data_ram_responder.sv
// mips_cpu_data_ram_responder
//   Memory end of the CPU data port. It is a word-organised RAM with byte
//   enables. A waitrequest handshake stretches every access to LATENCY wait
//   cycles. Accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) are flagged.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset
//   data_address      byte address (bits [1:0] ignored)
//   data_write        write request (wins over data_read when both are high)
//   data_read         read request
//   data_byteenable   write lanes, bit i -> bits [8i+7:8i]
//   data_writedata    write data
//   data_readdata     read data, valid in the ACK cycle
//   data_waitrequest  request not yet accepted, CPU holds inputs
//   access_error      one-cycle pulse on out-of-range or read+write access
//
// Optional feature (macro MIPS_DATA_RAM_STATS_EN)
//   Adds the saturating counters stat_reads, stat_writes and stat_errors.
//   Each counter advances once per completed access of its kind.
module mips_cpu_data_ram_responder #(
   parameter int unsigned DEPTH         = 1024,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
   parameter int unsigned LATENCY       = 1,
   parameter string       RAM_INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_address,
   input  logic        data_write,
   input  logic        data_read,
   input  logic [3:0]  data_byteenable,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   output logic        data_waitrequest,
   output logic        access_error
`ifdef MIPS_DATA_RAM_STATS_EN
   ,
   output logic [31:0] stat_reads,
   output logic [31:0] stat_writes,
   output logic [15:0] stat_errors
`endif
);

   localparam int          AW       = $clog2(DEPTH);
   localparam bit          ZERO_LAT = (LATENCY == 0);
   localparam logic [3:0]  CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);
   localparam logic [32:0] ADDR_LO  = {1'b0, BASE_ADDR};
   localparam logic [32:0] ADDR_HI  = ADDR_LO + (33'(DEPTH) << 2);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   logic [31:0]   mem [DEPTH];
   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          req;
   logic          conflict;
   logic          unused_off;

   state_t        state;
   logic [3:0]    cnt;
   logic          wr_p0;
   logic          inr_p0;
   logic          err_p0;
   logic [AW-1:0] idx_p0;
   logic [3:0]    be_p0;
   logic [31:0]   wd_p0;
   logic [31:0]   rdata_p1;

   logic          we;
   logic [AW-1:0] w_idx;
   logic [3:0]    w_be;
   logic [31:0]   w_data;

   // Decode stage: the range test uses 33 bits so BASE_ADDR + 4*DEPTH cannot wrap
   assign off        = data_address - BASE_ADDR;
   assign idx        = off[AW+1:2];
   assign unused_off = ^{off[31:AW+2], off[1:0]};
   assign in_range   = ({1'b0, data_address} >= ADDR_LO) && ({1'b0, data_address} < ADDR_HI);
   assign req        = data_read | data_write;
   assign conflict   = data_read & data_write;

   // Access latch (_p0): captured when a request is accepted in IDLE
   always_ff @(posedge clk) begin
      if (!ZERO_LAT && state == S_IDLE && req) begin
         idx_p0 <= idx;
         be_p0  <= data_byteenable;
         wd_p0  <= data_writedata;
      end
   end

   // Handshake FSM. An out-of-range access registers zero as its read word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         wr_p0    <= 1'b0;
         inr_p0   <= 1'b0;
         err_p0   <= 1'b0;
         rdata_p1 <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req && !ZERO_LAT) begin
                  wr_p0  <= data_write;
                  inr_p0 <= in_range;
                  err_p0 <= ~in_range | conflict;
                  cnt    <= CNT_INIT;
                  if (LATENCY == 1) begin
                     state    <= S_ACK;
                     rdata_p1 <= in_range ? mem[idx] : '0;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt <= 4'd1) begin
                  cnt      <= 4'd0;
                  state    <= S_ACK;
                  rdata_p1 <= inr_p0 ? mem[idx_p0] : '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_ACK:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Response stage. The outputs are gated by reset so that they drop at once when reset asserts.
   always_comb begin
      data_waitrequest = 1'b0;
      data_readdata    = rdata_p1;
      access_error     = 1'b0;
      if (ZERO_LAT) begin
         data_readdata = '0;
         if (reset && req) begin
            data_readdata = in_range ? mem[idx] : '0;
            access_error  = ~in_range | conflict;
         end
      end else begin
         data_waitrequest = reset && ((state == S_WAIT) || (state == S_IDLE && req));
         access_error     = (state == S_ACK) && err_p0;
      end
   end

   // Commit stage: an access aborted by reset never reaches the ACK edge
   always_comb begin
      if (ZERO_LAT) begin
         we     = reset && data_write && in_range;
         w_idx  = idx;
         w_be   = data_byteenable;
         w_data = data_writedata;
      end else begin
         we     = reset && (state == S_ACK) && wr_p0 && inr_p0;
         w_idx  = idx_p0;
         w_be   = be_p0;
         w_data = wd_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

`ifdef MIPS_DATA_RAM_STATS_EN
   logic done;
   logic done_wr;
   logic done_err;

   assign done     = ZERO_LAT ? req : (state == S_ACK);
   assign done_wr  = ZERO_LAT ? data_write : wr_p0;
   assign done_err = ZERO_LAT ? (~in_range | conflict) : err_p0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_reads  <= '0;
         stat_writes <= '0;
         stat_errors <= '0;
      end else if (done) begin
         if (done_wr) stat_writes <= sat_inc32(stat_writes);
         else         stat_reads  <= sat_inc32(stat_reads);
         if (done_err) stat_errors <= sat_inc16(stat_errors);
      end
   end
`endif

endmodule

// File: tb/tb_mips_cpu_data_ram_responder.sv
module tb_mips_cpu_data_ram_responder;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          NDUT  = 3;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 1;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr  [NDUT];
   logic [31:0] wdata [NDUT];
   logic [31:0] rdata [NDUT];
   logic [3:0]  be    [NDUT];
   logic        rd    [NDUT];
   logic        wr    [NDUT];
   logic        wait_ [NDUT];
   logic        err   [NDUT];
`ifdef MIPS_DATA_RAM_STATS_EN
   logic [31:0] s_rd [NDUT];
   logic [31:0] s_wr [NDUT];
   logic [15:0] s_er [NDUT];
`endif

   logic [31:0] ref_mem [NDUT][DEPTH];
   int          m_rd [NDUT];
   int          m_wr [NDUT];
   int          m_er [NDUT];
   int          n_vec = 0;
   int          n_miss = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mips_cpu_data_ram_responder #(
         .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 0))
      ) u_dut (
         .clk(clk), .reset(reset),
         .data_address(addr[g]), .data_write(wr[g]), .data_read(rd[g]),
         .data_byteenable(be[g]), .data_writedata(wdata[g]),
         .data_readdata(rdata[g]), .data_waitrequest(wait_[g]), .access_error(err[g])
`ifdef MIPS_DATA_RAM_STATS_EN
         , .stat_reads(s_rd[g]), .stat_writes(s_wr[g]), .stat_errors(s_er[g])
`endif
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete handshake on DUT k, checked against the reference memory
   task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
      int          waits;
      int          ix;
      bit          inr;
      logic [31:0] exp_rd;
      logic [31:0] word;
      inr    = (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * DEPTH)));
      ix     = inr ? int'((a - BASE) >> 2) : 0;
      exp_rd = inr ? ref_mem[k][ix] : 32'h0;
      @(negedge clk);
      addr[k] = a; rd[k] = r; wr[k] = w; be[k] = b; wdata[k] = d;
      waits = 0;
      #1;
      while (wait_[k] && waits < 40) begin
         waits++;
         @(negedge clk);
         #1;
      end
      chk($sformatf("waits[%0d]", k), waits, lat_of(k));
      if (r && !w) chk($sformatf("rdata[%0d]@%h", k, a), rdata[k], exp_rd);
      chk($sformatf("err[%0d]@%h", k, a), {31'd0, err[k]}, {31'd0, (!inr || (r && w))});
      if (w && inr) begin
         word = ref_mem[k][ix];
         for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
         ref_mem[k][ix] = word;
      end
      if (w) m_wr[k]++; else m_rd[k]++;
      if (!inr || (r && w)) m_er[k]++;
      @(negedge clk);
      rd[k] = 1'b0; wr[k] = 1'b0;
      #1;
      chk($sformatf("idle_wait[%0d]", k), {31'd0, wait_[k]}, 32'd0);
      chk($sformatf("idle_err[%0d]", k), {31'd0, err[k]}, 32'd0);
      if (r && !w) chk($sformatf("hold[%0d]", k), rdata[k], (lat_of(k) == 0) ? 32'h0 : exp_rd);
   endtask

`ifdef MIPS_DATA_RAM_STATS_EN
   task automatic chk_stats(input int k);
      chk($sformatf("stat_reads[%0d]", k), s_rd[k], m_rd[k]);
      chk($sformatf("stat_writes[%0d]", k), s_wr[k], m_wr[k]);
      chk($sformatf("stat_errors[%0d]", k), {16'd0, s_er[k]}, m_er[k]);
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         addr[k] = '0; wdata[k] = '0; be[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0;
         m_rd[k] = 0; m_wr[k] = 0; m_er[k] = 0;
      end
      #3 reset = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("rst_rdata[%0d]", k), rdata[k], 32'h0);
         chk($sformatf("rst_wait[%0d]", k), {31'd0, wait_[k]}, 32'd0);
         chk($sformatf("rst_err[%0d]", k), {31'd0, err[k]}, 32'd0);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Fill every word so the reference model is fully defined
      for (int k = 0; k < NDUT; k++)
         for (int i = 0; i < DEPTH; i++)
            access(k, 1'b0, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom);

      // Full write, read back, then a partial-lane overwrite
      for (int k = 0; k < NDUT; k++) begin
         access(k, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
         access(k, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
         access(k, 1'b0, 1'b1, 32'h1000, 4'b0101, 32'h11223344);
         access(k, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
         chk($sformatf("lanes[%0d]", k), ref_mem[k][0], 32'hDE22BE44);
         access(k, 1'b1, 1'b0, 32'h1004, 4'h0, 32'h0);
         // Out-of-range reads and a discarded write just below the base
         access(k, 1'b1, 1'b0, 32'h0FFC, 4'h0, 32'h0);
         access(k, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0);
         access(k, 1'b0, 1'b1, 32'h0FFC, 4'hF, 32'h55AA55AA);
         access(k, 1'b1, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 4'h0, 32'h0);
         access(k, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
         // A zero byteenable changes nothing
         access(k, 1'b0, 1'b1, 32'h1004, 4'h0, 32'hFFFFFFFF);
         access(k, 1'b1, 1'b0, 32'h1004, 4'h0, 32'h0);
      end

      // Reset asserted while a write to 0x1008 sits in WAIT
      @(negedge clk);
      addr[1] = 32'h1008; wr[1] = 1'b1; be[1] = 4'hF; wdata[1] = 32'h0BAD0BAD;
      @(negedge clk);
      #1;
      chk("pre_rst_wait", {31'd0, wait_[1]}, 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_wait", {31'd0, wait_[1]}, 32'd0);
      chk("mid_rst_rdata", rdata[1], 32'h0);
      chk("mid_rst_err", {31'd0, err[1]}, 32'd0);
      @(negedge clk);
      wr[1] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         m_rd[k] = 0; m_wr[k] = 0; m_er[k] = 0;
      end

      // Read and write together: the write wins and the error flag pulses
      access(1, 1'b1, 1'b1, 32'h100C, 4'hF, 32'hCAFEF00D);
`ifdef MIPS_DATA_RAM_STATS_EN
      chk("conflict_writes", s_wr[1], 32'd1);
      chk("conflict_errors", {16'd0, s_er[1]}, 32'd1);
      chk("conflict_reads", s_rd[1], 32'd0);
`endif
      access(1, 1'b1, 1'b0, 32'h1008, 4'h0, 32'h0);
      access(1, 1'b1, 1'b0, 32'h100C, 4'h0, 32'h0);
      chk("conflict_word", ref_mem[1][3], 32'hCAFEF00D);
      access(2, 1'b1, 1'b1, 32'h1010, 4'hF, 32'hCAFEF00D);
      access(2, 1'b1, 1'b0, 32'h1010, 4'h0, 32'h0);

      // Randomised traffic across all latencies, including near-boundary addresses
      for (int n = 0; n < 180; n++) begin
         int          k;
         bit          r;
         bit          w;
         logic [31:0] a;
         k = $urandom_range(0, NDUT - 1);
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         if (!r && !w) r = 1'b1;
         a = BASE - 32'd16 + 32'($urandom_range(0, 4 * DEPTH + 31));
         access(k, r, w, a, 4'($urandom_range(0, 15)), $urandom);
      end

`ifdef MIPS_DATA_RAM_STATS_EN
      for (int k = 0; k < NDUT; k++) chk_stats(k);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
